// File: rtl/parity_serializer_pkg.sv
// Shared definitions for the serial-parity blocks.
//   state_t      : serializer FSM state encoding (IDLE, DATA, PAR)
//   EVEN_PARITY  : parity-sense constant, frame carries an even number of ones
//   ODD_PARITY   : parity-sense constant, frame carries an odd number of ones
package parity_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam bit EVEN_PARITY = 1'b1;
  localparam bit ODD_PARITY  = 1'b0;

endpackage

// File: rtl/parity_serializer_acc.sv
// parity_acc: running-parity flip-flop for the serializer.
//   clock   : system clock
//   reset   : asynchronous active-high reset, clears parity
//   clear   : synchronous clear (start of a new frame)
//   enable  : fold bit_in into the running parity this cycle
//   bit_in  : bit being transmitted
//   parity  : XOR of all bits folded in since the last clear
module parity_acc (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic parity
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (clear) begin
      parity <= 1'b0;
    end else if (enable) begin
      parity <= parity ^ bit_in;
    end
  end

endmodule

// File: rtl/parity_serializer.sv
// parity_serializer: sends an N-bit word LSB first followed by one parity bit.
//   clock     : system clock, all state changes on posedge
//   reset     : asynchronous active-high reset
//   data_in   : parallel word to transmit
//   valid_in  : data_in holds a word to send
//   ready_out : a word is accepted this cycle (IDLE or PAR)
//   ser_out   : serial frame bit, 0 when ser_valid is low
//   ser_valid : ser_out carries a frame bit
//   ser_last  : ser_out carries the parity bit (last bit of the frame)
// Parameters: N data width (>= 1), EVEN parity sense (1 even, 0 odd).
module parity_serializer
  import parity_serializer_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter bit          EVEN = EVEN_PARITY
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last
);

  localparam int unsigned CW = $clog2(N) + 1;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           par;
  logic           xfer;
  logic           last_bit;
  logic           in_data;

  // ready_out depends on state only, so xfer never feeds back into outputs
  assign xfer     = valid_in && ready_out;
  assign in_data  = (state == DATA);
  assign last_bit = (cnt == CW'(N - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_out   = 1'b0;
    unique case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        ser_valid = 1'b1;
        ser_out   = shreg[0];
        if (last_bit) begin
          state_nxt = PAR;
        end
      end
      PAR: begin
        ready_out = 1'b1;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        ser_out   = par ^ !EVEN;
        // a word offered during the parity bit starts the next frame without a gap
        state_nxt = valid_in ? DATA : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (xfer) begin
      shreg <= data_in;
      cnt   <= '0;
    end else if (in_data) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  parity_acc u_parity_acc (
    .clock  (clock),
    .reset  (reset),
    .clear  (xfer),
    .enable (in_data),
    .bit_in (shreg[0]),
    .parity (par)
  );

endmodule

// File: tb/tb_parity_serializer.sv
module tb_parity_serializer;

  typedef struct {
    logic [7:0] word;
    int         par;
    time        t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dbus [3];
  logic       vbus [3];
  logic       rb   [3];
  logic       so   [3];
  logic       sv   [3];
  logic       sl   [3];

  exp_t q [3][$];
  int   last_run [3];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // d0: N=8 even, d1: N=8 odd, d2: N=1 even
  parity_serializer #(.N(8), .EVEN(1'b1)) u_d0 (
    .clock(clk), .reset(rst), .data_in(dbus[0]), .valid_in(vbus[0]),
    .ready_out(rb[0]), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]));
  parity_serializer #(.N(8), .EVEN(1'b0)) u_d1 (
    .clock(clk), .reset(rst), .data_in(dbus[1]), .valid_in(vbus[1]),
    .ready_out(rb[1]), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]));
  parity_serializer #(.N(1), .EVEN(1'b1)) u_d2 (
    .clock(clk), .reset(rst), .data_in(dbus[2][0:0]), .valid_in(vbus[2]),
    .ready_out(rb[2]), .ser_out(so[2]), .ser_valid(sv[2]), .ser_last(sl[2]));

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference parity: the bit that makes the frame's ones count even (ev=1) or odd (ev=0)
  function automatic int model_par(input logic [7:0] w, input int ev);
    int c;
    c = $countones(w);
    return ev ? (c % 2) : (1 - (c % 2));
  endfunction

  function automatic logic [7:0] dmask(input int g);
    return (g == 2) ? 8'h01 : 8'hFF;
  endfunction

  function automatic int dev(input int g);
    return (g == 1) ? 0 : 1;
  endfunction

  task automatic send(input int g, input logic [7:0] w, input int par);
    logic rdy;
    int   n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge clk);
      dbus[g] = w;
      vbus[g] = 1'b1;
      rdy = rb[g];
      @(posedge clk);
      if (rdy) begin
        e.word = w & dmask(g);
        e.par  = par;
        e.t    = $time;
        q[g].push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        note_fail($sformatf("d%0d accept timeout", g));
        break;
      end
    end
  endtask

  task automatic idle(input int g);
    @(negedge clk);
    vbus[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (q[g].size() == 0 && !sv[g]) break;
      n++;
      if (n > 300) begin
        note_fail($sformatf("d%0d drain timeout", g));
        break;
      end
    end
  endtask

  task automatic rand_stream(input int g, input int frames);
    logic [7:0] w;
    for (int i = 0; i < frames; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(g);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      w = 8'($urandom) & dmask(g);
      send(g, w, model_par(w, dev(g)));
    end
    idle(g);
    wait_idle(g);
  endtask

  // Monitors: deserialize each DUT's stream and compare against the queued expectations
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int NW = (g == 2) ? 1 : 8;
    localparam int EV = (g == 1) ? 0 : 1;
    int         bitpos = 0;
    int         ones = 0;
    int         run = 0;
    logic [7:0] word = '0;
    exp_t       e;

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("d%0d reset ser_valid", g), int'(sv[g]), 0);
        chk($sformatf("d%0d reset ser_out", g), int'(so[g]), 0);
        chk($sformatf("d%0d reset ser_last", g), int'(sl[g]), 0);
        chk($sformatf("d%0d reset ready_out", g), int'(rb[g]), 1);
        bitpos = 0;
        ones   = 0;
        run    = 0;
        word   = '0;
      end else if (sv[g]) begin
        run++;
        if (bitpos == 0) begin
          if (q[g].size() == 0) note_fail($sformatf("d%0d unexpected frame", g));
          else chk($sformatf("d%0d first-bit latency", g), int'($time - q[g][0].t), 5);
        end
        if (bitpos < NW) begin
          chk($sformatf("d%0d data ser_last", g), int'(sl[g]), 0);
          chk($sformatf("d%0d data ready_out", g), int'(rb[g]), 0);
          word[bitpos] = so[g];
          ones += int'(so[g]);
          bitpos++;
        end else begin
          chk($sformatf("d%0d parity ser_last", g), int'(sl[g]), 1);
          chk($sformatf("d%0d parity ready_out", g), int'(rb[g]), 1);
          if (q[g].size() != 0) begin
            e = q[g].pop_front();
            chk($sformatf("d%0d word", g), int'(word), int'(e.word));
            chk($sformatf("d%0d parity bit", g), int'(so[g]), e.par);
          end
          chk($sformatf("d%0d frame ones parity", g), (ones + int'(so[g])) % 2, EV ? 0 : 1);
          bitpos = 0;
          ones   = 0;
          word   = '0;
        end
      end else begin
        chk($sformatf("d%0d idle ser_out", g), int'(so[g]), 0);
        chk($sformatf("d%0d idle ser_last", g), int'(sl[g]), 0);
        chk($sformatf("d%0d idle ready_out", g), int'(rb[g]), 1);
        if (bitpos != 0) note_fail($sformatf("d%0d gap inside frame at bit %0d", g, bitpos));
        bitpos = 0;
        ones   = 0;
        word   = '0;
        if (run != 0) last_run[g] = run;
        run = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      dbus[i] = '0;
      vbus[i] = 1'b0;
      last_run[i] = 0;
    end
    #1;
    chk("reset-time ready_out", int'(rb[0]), 1);
    chk("reset-time ser_valid", int'(sv[0]), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // A5: LSB-first reconstruction, even parity 0, 9 valid cycles
    send(0, 8'hA5, 0);
    idle(0);
    wait_idle(0);
    chk("A5 ser_valid cycles", last_run[0], 9);

    // 01: even sense gives 1, odd sense gives 0
    send(0, 8'h01, 1);
    idle(0);
    wait_idle(0);
    send(1, 8'h01, 0);
    idle(1);
    wait_idle(1);

    // FF then 00 with valid held high: gapless 18-cycle burst
    send(0, 8'hFF, 0);
    send(0, 8'h00, 0);
    idle(0);
    wait_idle(0);
    chk("back-to-back run length", last_run[0], 18);

    // reset during the 3rd data bit aborts the frame
    send(0, 8'hC3, model_par(8'hC3, 1));
    idle(0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort ser_valid", int'(sv[0]), 0);
    chk("abort ser_out", int'(so[0]), 0);
    chk("abort ser_last", int'(sl[0]), 0);
    chk("abort ready_out", int'(rb[0]), 1);
    q[0].delete();
    @(negedge clk);
    #1 rst = 1'b0;
    send(0, 8'h3C, 0);
    idle(0);
    wait_idle(0);

    // input activity during DATA is ignored
    send(0, 8'h96, model_par(8'h96, 1));
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      dbus[0] = 8'($urandom);
      vbus[0] = i[0];
    end
    @(negedge clk);
    vbus[0] = 1'b0;
    wait_idle(0);
    chk("disturb run length", last_run[0], 9);

    fork
      rand_stream(0, 1000);
      rand_stream(1, 300);
      rand_stream(2, 1000);
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
